// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath: controller state encoding and default width.
package mont_pkg;

    localparam int MONT_WIDTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mont_state_e;

endpackage

// File: rtl/mont_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1 with wrap.
module mont_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o
);

    // Scan from lowest priority to highest so the closest candidate after last overwrites the rest.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            valid_o  = valid_o | req_i[(int'(last_i) + k) % NUM_REQ];
            winner_o = req_i[(int'(last_i) + k) % NUM_REQ] ? IDX_W'((int'(last_i) + k) % NUM_REQ)
                                                           : winner_o;
        end
    end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier core among NUM_REQ requesters,
// one multiplication in flight at a time.
module mont_mul_arbiter
    import mont_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = MONT_WIDTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_m,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done_out,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic [WIDTH-1:0]         mul_m,
    input  logic [WIDTH-1:0]         mul_result,
    input  logic                     mul_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    mont_state_e          state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 busy_q;
    logic                 start_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     m_q;
    logic [IDX_W-1:0]     last_q;

    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_win_s;

    mont_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .valid_o  (pick_valid_s),
        .winner_o (pick_win_s)
    );

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        a_q     <= req_a[int'(pick_win_s)*WIDTH +: WIDTH];
                        b_q     <= req_b[int'(pick_win_s)*WIDTH +: WIDTH];
                        m_q     <= req_m[int'(pick_win_s)*WIDTH +: WIDTH];
                        grant_q <= NUM_REQ'(1) << pick_win_s;
                        last_q  <= pick_win_s;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is only honoured here; stray pulses elsewhere fall to the default hold.
                    if (mul_done) begin
                        result_q <= mul_result;
                        done_q   <= grant_q;
                        state_q  <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done_out  = done_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_m     = m_q;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed self-checking bench for mont_mul_arbiter with a 10-cycle behavioural (a*b) mod m core.
module tb_mont_mul_arbiter;

    localparam int NR = 2;
    localparam int W  = 16;

    logic            clk;
    logic            resetn;
    logic [NR-1:0]   req;
    logic [W-1:0]    a0, b0, m0, a1, b1, m1;
    logic [NR*W-1:0] req_a, req_b, req_m;
    logic [NR-1:0]   grant, done_out;
    logic [W-1:0]    result;
    logic            busy, mul_start;
    logic [W-1:0]    mul_a, mul_b, mul_m, mul_result;
    logic            mul_done;

    logic [W-1:0]    core_res;
    logic            core_done;
    logic            force_done;
    logic [31:0]     ca, cb, cm;
    int              cnt;
    logic            core_busy;

    int checks = 0;
    int errors = 0;

    assign req_a = {a1, a0};
    assign req_b = {b1, b0};
    assign req_m = {m1, m0};
    assign mul_done   = core_done | force_done;
    assign mul_result = force_done ? 16'hBEEF : core_res;

    mont_mul_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .grant(grant), .done_out(done_out), .result(result), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier core sharing the arbiter reset.
    always @(posedge clk) begin
        if (!resetn) begin
            cnt <= 0; core_busy <= 1'b0; core_done <= 1'b0; core_res <= '0;
        end else begin
            core_done <= 1'b0;
            if (mul_start) begin
                ca <= 32'(mul_a); cb <= 32'(mul_b); cm <= 32'(mul_m);
                cnt <= 10; core_busy <= 1'b1;
            end else if (core_busy) begin
                if (cnt == 1) begin
                    core_done <= 1'b1;
                    core_res  <= W'((ca * cb) % cm);
                    core_busy <= 1'b0;
                end
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Waits for done_out, checking it lands exactly one cycle after mul_done.
    task automatic wait_done(input string tag);
        int md = -1;
        int dn = -1;
        for (int c = 0; c < 60 && dn < 0; c++) begin
            step();
            if (mul_done && md < 0) md = c;
            if (done_out != '0) dn = c;
        end
        chk({tag, "_seen"}, 32'(dn >= 0), 32'd1);
        chk({tag, "_lat"}, 32'(dn - md), 32'd1);
    endtask

    task automatic wait_grant(input string tag);
        int g = -1;
        for (int c = 0; c < 10 && g < 0; c++) begin
            if (grant != '0) g = c;
            else step();
        end
        chk({tag, "_seen"}, 32'(g >= 0), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; req = '0; force_done = 1'b0;
        a0 = 16'd3; b0 = 16'd5; m0 = 16'd7;
        a1 = 16'd4; b1 = 16'd4; m1 = 16'd11;
        step(); step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        resetn = 1'b1;
        step();

        // Single request
        req = 2'b01;
        step();
        chk("s_grant", 32'(grant), 32'd1);
        chk("s_start", 32'(mul_start), 32'd1);
        chk("s_busy", 32'(busy), 32'd1);
        chk("s_mul_a", 32'(mul_a), 32'd3);
        chk("s_mul_m", 32'(mul_m), 32'd7);
        step();
        chk("s_start_1cyc", 32'(mul_start), 32'd0);
        wait_done("s_done");
        chk("s_done_vec", 32'(done_out), 32'd1);
        chk("s_result", 32'(result), 32'd1);
        chk("s_grant_resp", 32'(grant), 32'd1);
        req = 2'b00;
        step();
        chk("s_busy_after", 32'(busy), 32'd0);
        chk("s_grant_after", 32'(grant), 32'd0);
        chk("s_done_after", 32'(done_out), 32'd0);

        // Simultaneous requests from reset
        resetn = 1'b0; step(); resetn = 1'b1;
        a0 = 16'd2; b0 = 16'd3; m0 = 16'd11;
        req = 2'b11;
        step();
        chk("sim_grant0", 32'(grant), 32'd1);
        wait_done("sim_done0");
        chk("sim_done0_vec", 32'(done_out), 32'd1);
        chk("sim_result0", 32'(result), 32'd6);
        req = 2'b10;
        step();
        chk("sim_gap", 32'(grant), 32'd0);
        step();
        chk("sim_grant1", 32'(grant), 32'd2);
        chk("sim_start1", 32'(mul_start), 32'd1);
        wait_done("sim_done1");
        chk("sim_done1_vec", 32'(done_out), 32'd2);
        chk("sim_result1", 32'(result), 32'd5);
        req = 2'b00;
        step();

        // Fairness: six back-to-back operations with immediate re-requests
        req = 2'b11;
        for (int op = 0; op < 6; op++) begin
            wait_grant("fair_grant");
            chk("fair_order", 32'(grant), (op % 2 == 0) ? 32'd1 : 32'd2);
            wait_done("fair_done");
            chk("fair_result", 32'(result), (op % 2 == 0) ? 32'd6 : 32'd5);
            req = req & ~done_out;
            step();
            req = 2'b11;
        end
        req = 2'b00;
        step(); step();

        // Spurious mul_done in IDLE and during ISSUE
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("sp_idle_busy", 32'(busy), 32'd0);
        chk("sp_idle_done", 32'(done_out), 32'd0);
        chk("sp_idle_result", 32'(result), 32'd5);
        a0 = 16'd3; b0 = 16'd5; m0 = 16'd7;
        req = 2'b01;
        step();
        chk("sp_issue_start", 32'(mul_start), 32'd1);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("sp_issue_result", 32'(result), 32'd5);
        chk("sp_issue_done", 32'(done_out), 32'd0);
        chk("sp_issue_busy", 32'(busy), 32'd1);
        wait_done("sp_done");
        chk("sp_result", 32'(result), 32'd1);
        req = 2'b00;
        step();

        // Reset during WAIT
        req = 2'b01;
        step(); step(); step(); step();
        resetn = 1'b0; req = 2'b00;
        step();
        resetn = 1'b1;
        chk("rw_grant", 32'(grant), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_done", 32'(done_out), 32'd0);
        for (int c = 0; c < 14; c++) begin
            step();
            chk("rw_quiet", 32'(done_out), 32'd0);
        end
        req = 2'b10;
        step();
        chk("rw_grant1", 32'(grant), 32'd2);
        wait_done("rw_done1");
        chk("rw_done1_vec", 32'(done_out), 32'd2);
        chk("rw_result1", 32'(result), 32'd5);
        req = 2'b00;
        step();

        // req[0] dropped during WAIT
        a0 = 16'd2; b0 = 16'd3; m0 = 16'd11;
        req = 2'b11;
        step();
        chk("dr_grant0", 32'(grant), 32'd1);
        step(); step(); step();
        req = 2'b10;
        wait_done("dr_done0");
        chk("dr_done0_vec", 32'(done_out), 32'd1);
        chk("dr_result0", 32'(result), 32'd6);
        step(); step();
        chk("dr_grant1", 32'(grant), 32'd2);
        wait_done("dr_done1");
        chk("dr_result1", 32'(result), 32'd5);
        req = 2'b00;
        step(); step();
        chk("dr_idle", 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
